// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor sizes, queue entry type and history helper
package bp_pkg;

  localparam int GHT_BIT   = 4;
  localparam int BUQ_DEPTH = 8;
  localparam int PC_BIT    = 32;
  localparam int TAG_BIT   = $clog2(BUQ_DEPTH);

  typedef struct packed {
    logic              valid;
    logic              resolved;
    logic              pred;
    logic              taken;
    logic [PC_BIT-1:0] pc;
    logic [GHT_BIT-1:0] ght;
  } buq_entry_t;

  function automatic logic [GHT_BIT-1:0] ght_shift(input logic [GHT_BIT-1:0] ght,
                                                   input logic             taken_bit);
    return {ght[GHT_BIT-2:0], taken_bit};
  endfunction

endpackage

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order branch update queue feeding the GAS update port
// Optional retire/mispredict statistics counters under BUQ_STATS_EN.
module branch_update_queue
  import bp_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               alloc_valid,
  input  logic [PC_BIT-1:0]  alloc_pc,
  input  logic               alloc_pred,
  input  logic [GHT_BIT-1:0] alloc_ght,
  output logic               alloc_ready,
  output logic [TAG_BIT-1:0] alloc_tag,
  input  logic               resolve_valid,
  input  logic [TAG_BIT-1:0] resolve_tag,
  input  logic               resolve_taken,
  output logic               upd_valid,
  output logic [PC_BIT-1:0]  upd_pc,
  output logic               upd_taken,
  output logic               mispredict,
  output logic [TAG_BIT-1:0] mispredict_tag,
  output logic [GHT_BIT-1:0] recover_ght,
  output logic [TAG_BIT:0]   count,
  output logic               full,
`ifdef BUQ_STATS_EN
  output logic [31:0]        retire_cnt,
  output logic [31:0]        mispred_cnt,
`endif
  output logic               empty
);

  localparam int CNT_BIT = TAG_BIT + 1;

  buq_entry_t         entries_q [BUQ_DEPTH];
  buq_entry_t         entries_d [BUQ_DEPTH];
  logic [TAG_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_BIT-1:0] count_q, count_d;
  logic               upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [PC_BIT-1:0]  upd_pc_q, upd_pc_d;
  logic               mp_q, mp_d;
  logic [TAG_BIT-1:0] mp_tag_q, mp_tag_d;
  logic [GHT_BIT-1:0] recover_q, recover_d;

  buq_entry_t         res_e, head_e;
  logic               res_ok, mp_now, push, pop;
  logic [TAG_BIT-1:0] res_age;

  assign res_e       = entries_q[resolve_tag];
  assign head_e      = entries_q[head_q];
  assign res_ok      = enable & resolve_valid & res_e.valid & ~res_e.resolved;
  assign mp_now      = res_ok & (resolve_taken != res_e.pred);
  assign full        = (count_q == CNT_BIT'(BUQ_DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = enable & ~full & ~mp_now;
  assign alloc_tag   = tail_q;
  assign push        = alloc_valid & alloc_ready;
  assign pop         = enable & head_e.valid & head_e.resolved;
  // Age relative to head orders entries in program order across the wrap.
  assign res_age     = resolve_tag - head_q;

  always_comb begin
    entries_d   = entries_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    upd_valid_d = 1'b0;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    mp_d        = 1'b0;
    mp_tag_d    = mp_tag_q;
    recover_d   = recover_q;

    if (pop) begin
      upd_valid_d              = 1'b1;
      upd_pc_d                 = head_e.pc;
      upd_taken_d              = head_e.taken;
      entries_d[head_q].valid  = 1'b0;
      head_d                   = head_q + 1'b1;
    end

    if (res_ok) begin
      entries_d[resolve_tag].resolved = 1'b1;
      entries_d[resolve_tag].taken    = resolve_taken;
    end

    if (mp_now) begin
      for (int i = 0; i < BUQ_DEPTH; i++) begin
        if ((TAG_BIT'(i) - head_q) > res_age) entries_d[i].valid = 1'b0;
      end
      tail_d    = resolve_tag + 1'b1;
      count_d   = CNT_BIT'(res_age) + CNT_BIT'(1) - CNT_BIT'(pop);
      mp_d      = 1'b1;
      mp_tag_d  = resolve_tag;
      recover_d = ght_shift(res_e.ght, resolve_taken);
    end else begin
      if (push) begin
        entries_d[tail_q] = '{valid: 1'b1, resolved: 1'b0, pred: alloc_pred, taken: 1'b0,
                              pc: alloc_pc, ght: alloc_ght};
        tail_d            = tail_q + 1'b1;
      end
      count_d = count_q + CNT_BIT'(push) - CNT_BIT'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUQ_DEPTH; i++) entries_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      mp_q        <= 1'b0;
      mp_tag_q    <= '0;
      recover_q   <= '0;
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      mp_q        <= mp_d;
      mp_tag_q    <= mp_tag_d;
      recover_q   <= recover_d;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign mispredict     = mp_q;
  assign mispredict_tag = mp_tag_q;
  assign recover_ght    = recover_q;
  assign count          = count_q;

`ifdef BUQ_STATS_EN
  logic [31:0] retire_cnt_q, mispred_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (pop && (retire_cnt_q != '1))     retire_cnt_q  <= retire_cnt_q + 32'd1;
      if (mp_now && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign retire_cnt  = retire_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - scoreboard bench for branch_update_queue
module tb_branch_update_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_pred;
  logic [3:0]  alloc_ght;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        resolve_valid;
  logic [2:0]  resolve_tag;
  logic        resolve_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        mispredict;
  logic [2:0]  mispredict_tag;
  logic [3:0]  recover_ght;
  logic [3:0]  count;
  logic        full;
  logic        empty;
`ifdef BUQ_STATS_EN
  logic [31:0] retire_cnt;
  logic [31:0] mispred_cnt;
`endif

  branch_update_queue dut (
    .clock(clock), .reset(reset), .enable(enable),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .alloc_ght(alloc_ght), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag), .recover_ght(recover_ght),
    .count(count), .full(full),
`ifdef BUQ_STATS_EN
    .retire_cnt(retire_cnt), .mispred_cnt(mispred_cnt),
`endif
    .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } upd_t;

  upd_t exp_q[$];
  upd_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge clock) begin
    if (!reset && upd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL upd_unexpected: got pc=%h taken=%b, expected no update", upd_pc, upd_taken);
      end else begin
        mon_e = exp_q.pop_front();
        if (upd_pc !== mon_e.pc || upd_taken !== mon_e.taken)
          $display("FAIL upd_order: got pc=%h taken=%b, expected pc=%h taken=%b",
                   upd_pc, upd_taken, mon_e.pc, mon_e.taken);
        else n_pass++;
      end
    end
  end

  task automatic expect_upd(input logic [31:0] pc, input logic taken);
    upd_t e;
    e.pc = pc;
    e.taken = taken;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0; alloc_ght = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    enable = 1'b1;
    reset  = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic pred, input logic [3:0] ght,
                         output logic acc, output logic [2:0] tag);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_pred = pred; alloc_ght = ght;
    #1;
    acc = alloc_ready;
    tag = alloc_tag;
    @(posedge clock); #1;
    alloc_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic [2:0] tag, input logic taken);
    resolve_valid = 1'b1; resolve_tag = tag; resolve_taken = taken;
    @(posedge clock); #1;
    resolve_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    enable = 1'b1;
    reset  = 1'b1;
    #2;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b, expected 1", empty); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d, expected 0", count); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready: got %b, expected 1", alloc_ready); else n_pass++;
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid: got %b, expected 0", upd_valid); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict: got %b, expected 0", mispredict); else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_in_order_retire();
    logic acc; logic [2:0] tag;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_push(32'(4 * i), 1'b0, 4'h0, acc, tag);
      n_checks++;
      if (acc !== 1'b1 || tag !== 3'(i)) $display("FAIL order_push_tag%0d: got acc=%b tag=%0d, expected acc=1 tag=%0d", i, acc, tag, i);
      else n_pass++;
    end
    expect_upd(32'h0, 1'b0);
    expect_upd(32'h4, 1'b0);
    do_resolve(3'd1, 1'b0);
    do_resolve(3'd0, 1'b0);
    idle(3);
    n_checks++; if (count !== 4'd1) $display("FAIL order_count: got %0d, expected 1", count); else n_pass++;
    expect_upd(32'h8, 1'b0);
    do_resolve(3'd2, 1'b0);
    idle(3);
    n_checks++; if (empty !== 1'b1 || exp_q.size() != 0) $display("FAIL order_drain: got empty=%b pending=%0d, expected 1/0", empty, exp_q.size()); else n_pass++;
  endtask

  task automatic test_mispredict();
    logic acc; logic [2:0] tag;
    do_reset();
    do_push(32'h10, 1'b0, 4'b0000, acc, tag);
    do_push(32'h14, 1'b0, 4'b0001, acc, tag);
    do_push(32'h18, 1'b0, 4'b0011, acc, tag);
    expect_upd(32'h10, 1'b1);
    do_resolve(3'd0, 1'b1);
    n_checks++; if (mispredict !== 1'b1) $display("FAIL mp_pulse: got %b, expected 1", mispredict); else n_pass++;
    n_checks++; if (mispredict_tag !== 3'd0) $display("FAIL mp_tag: got %0d, expected 0", mispredict_tag); else n_pass++;
    n_checks++; if (recover_ght !== 4'b0001) $display("FAIL mp_recover_ght: got %b, expected 0001", recover_ght); else n_pass++;
    n_checks++; if (count !== 4'd1) $display("FAIL mp_count: got %0d, expected 1", count); else n_pass++;
    do_push(32'h20, 1'b0, 4'b0001, acc, tag);
    n_checks++; if (acc !== 1'b1 || tag !== 3'd1) $display("FAIL mp_next_tag: got acc=%b tag=%0d, expected acc=1 tag=1", acc, tag); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL mp_one_cycle: got %b, expected 0", mispredict); else n_pass++;
    expect_upd(32'h20, 1'b0);
    do_resolve(3'd1, 1'b0);
    idle(3);
    n_checks++; if (empty !== 1'b1 || exp_q.size() != 0) $display("FAIL mp_drain: got empty=%b pending=%0d, expected 1/0", empty, exp_q.size()); else n_pass++;
  endtask

  task automatic test_full_wrap();
    logic acc; logic [2:0] tag;
    do_reset();
    for (int i = 0; i < 8; i++) do_push(32'h100 + 32'(4 * i), 1'b1, 4'(i), acc, tag);
    n_checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 4'd8)
      $display("FAIL full_flags: got full=%b ready=%b count=%0d, expected 1/0/8", full, alloc_ready, count); else n_pass++;
    do_push(32'hDEAD, 1'b1, 4'h0, acc, tag);
    n_checks++; if (acc !== 1'b0 || count !== 4'd8) $display("FAIL full_drop9: got acc=%b count=%0d, expected 0/8", acc, count); else n_pass++;
    expect_upd(32'h100, 1'b1);
    do_resolve(3'd0, 1'b1);
    do_push(32'hBEEF, 1'b1, 4'h0, acc, tag);
    n_checks++; if (acc !== 1'b0) $display("FAIL full_pop_same_edge: got acc=%b, expected 0", acc); else n_pass++;
    do_push(32'h200, 1'b1, 4'h0, acc, tag);
    n_checks++; if (acc !== 1'b1 || tag !== 3'd0 || count !== 4'd8)
      $display("FAIL full_wrap_push: got acc=%b tag=%0d count=%0d, expected 1/0/8", acc, tag, count); else n_pass++;
    for (int i = 1; i < 8; i++) begin
      expect_upd(32'h100 + 32'(4 * i), 1'b1);
      do_resolve(3'(i), 1'b1);
    end
    expect_upd(32'h200, 1'b1);
    do_resolve(3'd0, 1'b1);
    idle(4);
    n_checks++; if (empty !== 1'b1 || exp_q.size() != 0) $display("FAIL full_drain: got empty=%b pending=%0d, expected 1/0", empty, exp_q.size()); else n_pass++;
  endtask

  task automatic test_ignored_resolve();
    logic acc; logic [2:0] tag;
    do_reset();
    do_push(32'h40, 1'b0, 4'h2, acc, tag);
    do_push(32'h44, 1'b0, 4'h5, acc, tag);
    do_resolve(3'd1, 1'b0);
    do_resolve(3'd1, 1'b1);
    n_checks++; if (mispredict !== 1'b0 || count !== 4'd2)
      $display("FAIL ign_resolved: got mp=%b count=%0d, expected 0/2", mispredict, count); else n_pass++;
    do_resolve(3'd5, 1'b1);
    n_checks++; if (mispredict !== 1'b0 || count !== 4'd2 || upd_valid !== 1'b0)
      $display("FAIL ign_invalid: got mp=%b count=%0d upd=%b, expected 0/2/0", mispredict, count, upd_valid); else n_pass++;
    expect_upd(32'h40, 1'b0);
    expect_upd(32'h44, 1'b0);
    do_resolve(3'd0, 1'b0);
    idle(3);
    n_checks++; if (empty !== 1'b1 || exp_q.size() != 0) $display("FAIL ign_drain: got empty=%b pending=%0d, expected 1/0", empty, exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_retire();
    logic acc; logic [2:0] tag;
    do_reset();
    for (int i = 0; i < 4; i++) do_push(32'h80 + 32'(4 * i), 1'b0, 4'h0, acc, tag);
    do_resolve(3'd3, 1'b0);
    do_resolve(3'd2, 1'b0);
    do_resolve(3'd1, 1'b0);
    expect_upd(32'h80, 1'b0);
    do_resolve(3'd0, 1'b0);
    @(posedge clock); #1;
    n_checks++; if (upd_valid !== 1'b1) $display("FAIL rst_first_pop: got upd=%b, expected 1", upd_valid); else n_pass++;
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    n_checks++; if (upd_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1)
      $display("FAIL rst_async_clear: got upd=%b count=%0d empty=%b, expected 0/0/1", upd_valid, count, empty); else n_pass++;
`ifdef BUQ_STATS_EN
    n_checks++; if (retire_cnt !== 32'd0 || mispred_cnt !== 32'd0)
      $display("FAIL rst_stats: got retire=%0d mispred=%0d, expected 0/0", retire_cnt, mispred_cnt); else n_pass++;
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    idle(3);
    n_checks++; if (count !== 4'd0 || exp_q.size() != 0)
      $display("FAIL rst_no_pending: got count=%0d pending=%0d, expected 0/0", count, exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_in_order_retire();
    test_mispredict();
    test_full_wrap();
    test_ignored_resolve();
    test_reset_mid_retire();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
